// File: rtl/alu_seq_acc.sv
// Registered WIDTH-bit ALU with an accumulator, {Z,N,C,V} flags, barrel shifts and
// a shift-add multiplier that takes WIDTH step cycles. Handshakes are valid/ready.
module alu_seq_acc #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             use_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic [WIDTH-1:0] acc,
    output logic             busy
);
    localparam int SW = $clog2(WIDTH);
    localparam logic [SW-1:0] LAST_STEP = SW'(WIDTH - 1);

    // Handshake: an operation transfers on a rising edge where in_valid & in_ready;
    // a result transfers on an edge where out_valid & out_ready (ena=1 required for both).
    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t             state_q, state_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [3:0]         flags_q, flags_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [SW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;

    logic [WIDTH-1:0]   op_a, alu_res, flag_res;
    logic               alu_c, alu_v, cin, accept;
    logic [SW-1:0]      sh;
    logic [WIDTH:0]     add_ext, sub_ext, shl_ext, shr_ext;
    logic [2*WIDTH-1:0] prod_nxt;

    assign in_ready  = ena & ~rst & (state_q == S_IDLE) & (~out_valid_q | out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;
    assign acc       = acc_q;
    assign busy      = (state_q == S_MUL);

    assign op_a     = use_acc ? acc_q : a;
    assign sh       = b[SW-1:0];
    assign cin      = (op == 4'd10) & flags_q[1];
    assign add_ext  = {1'b0, op_a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign sub_ext  = {1'b0, op_a} - {1'b0, b};
    // Bit WIDTH of shl_ext / bit 0 of shr_ext is the last bit pushed out (0 for sh=0).
    assign shl_ext  = {1'b0, op_a} << sh;
    assign shr_ext  = {op_a, 1'b0} >> sh;
    assign prod_nxt = prod_q + (mplier_q[0] ? mcand_q : {2*WIDTH{1'b0}});

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            4'd0, 4'd10: begin
                alu_res = add_ext[WIDTH-1:0];
                alu_c   = add_ext[WIDTH];
                alu_v   = (op_a[WIDTH-1] == b[WIDTH-1]) & (alu_res[WIDTH-1] != op_a[WIDTH-1]);
            end
            4'd1, 4'd11: begin
                alu_res = sub_ext[WIDTH-1:0];
                alu_c   = sub_ext[WIDTH];
                alu_v   = (op_a[WIDTH-1] != b[WIDTH-1]) & (alu_res[WIDTH-1] != op_a[WIDTH-1]);
            end
            4'd2: alu_res = op_a & b;
            4'd3: alu_res = op_a | b;
            4'd4: alu_res = op_a ^ b;
            4'd5: alu_res = ~op_a;
            4'd6: alu_res = b;
            4'd7: begin
                alu_res = shl_ext[WIDTH-1:0];
                alu_c   = shl_ext[WIDTH];
            end
            4'd8: begin
                alu_res = shr_ext[WIDTH:1];
                alu_c   = shr_ext[0];
            end
            default: alu_res = '0;
        endcase
        // CMP keeps the difference for flags only; the visible result is operand A.
        flag_res = alu_res;
        if (op == 4'd11) alu_res = op_a;
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        flags_d     = flags_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        prod_d      = prod_q;
        if (ena) begin
            if (out_ready) out_valid_d = 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (op == 4'd9) begin
                            state_d  = S_MUL;
                            cnt_d    = '0;
                            mcand_d  = {{WIDTH{1'b0}}, op_a};
                            mplier_d = b;
                            prod_d   = '0;
                        end else begin
                            out_valid_d = 1'b1;
                            result_d    = alu_res;
                            flags_d     = {flag_res == '0, flag_res[WIDTH-1], alu_c, alu_v};
                            if (op < 4'd11) acc_d = alu_res;
                        end
                    end
                end
                S_MUL: begin
                    prod_d   = prod_nxt;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == LAST_STEP) begin
                        state_d     = S_IDLE;
                        out_valid_d = 1'b1;
                        result_d    = prod_nxt[WIDTH-1:0];
                        flags_d     = {prod_nxt[WIDTH-1:0] == '0, prod_nxt[WIDTH-1],
                                       |prod_nxt[2*WIDTH-1:WIDTH], 1'b0};
                        acc_d       = prod_nxt[WIDTH-1:0];
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            prod_q      <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            prod_q      <= prod_d;
        end
    end
endmodule

// File: tb/tb_alu_seq_acc.sv
// Directed bench for alu_seq_acc at WIDTH=8; expected values are hand-computed.
module tb_alu_seq_acc;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst, ena, in_valid, in_ready, use_acc, out_valid, out_ready, busy;
  logic [3:0] op, flags;
  logic [W-1:0] a, b, result, acc;

  int n_vec = 0;
  int n_err = 0;

  alu_seq_acc #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .ena(ena), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .use_acc(use_acc), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .flags(flags), .acc(acc), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op, wait (bounded) for in_ready, transfer it on the next edge.
  task automatic do_op(input logic [3:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                       input logic ua);
    int cnt;
    op = o; a = va; b = vb; use_acc = ua; in_valid = 1'b1;
    #1;
    cnt = 0;
    while (!in_ready && cnt < 50) begin
      tick();
      cnt++;
    end
    check("accept_timeout", 16'(cnt >= 50), 16'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [W-1:0] r, input logic [3:0] f);
    check({tag, "_valid"}, 16'(out_valid), 16'd1);
    check({tag, "_result"}, 16'(result), 16'(r));
    check({tag, "_flags"}, 16'(flags), 16'(f));
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1; in_valid = 1'b0; use_acc = 1'b0; out_ready = 1'b1;
    op = 4'd0; a = '0; b = '0;
    tick(); tick();
    check("rst_out_valid", 16'(out_valid), 16'd0);
    check("rst_result", 16'(result), 16'd0);
    check("rst_flags", 16'(flags), 16'd0);
    check("rst_acc", 16'(acc), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_in_ready", 16'(in_ready), 16'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 16'(in_ready), 16'd1);

    // Arithmetic and flags ({Z,N,C,V})
    do_op(4'd0, 8'hF0, 8'h20, 1'b0); expect_out("add_carry", 8'h10, 4'b0010);
    check("add_acc", 16'(acc), 16'h10);
    do_op(4'd1, 8'h05, 8'h07, 1'b0); expect_out("sub_borrow", 8'hFE, 4'b0110);
    do_op(4'd0, 8'h7F, 8'h01, 1'b0); expect_out("add_ovf", 8'h80, 4'b0101);
    do_op(4'd0, 8'hFF, 8'h01, 1'b0); expect_out("add_zero", 8'h00, 4'b1010);
    do_op(4'd10, 8'h10, 8'h20, 1'b0); expect_out("adc_cin", 8'h31, 4'b0000);
    do_op(4'd10, 8'h10, 8'h20, 1'b0); expect_out("adc_nocin", 8'h30, 4'b0000);
    // Logic and moves
    do_op(4'd2, 8'hF0, 8'h3C, 1'b0); expect_out("and", 8'h30, 4'b0000);
    do_op(4'd3, 8'h0F, 8'h30, 1'b0); expect_out("or", 8'h3F, 4'b0000);
    do_op(4'd4, 8'hFF, 8'h0F, 1'b0); expect_out("xor", 8'hF0, 4'b0100);
    do_op(4'd5, 8'h0F, 8'h00, 1'b0); expect_out("not", 8'hF0, 4'b0100);
    do_op(4'd6, 8'hAA, 8'h00, 1'b0); expect_out("pass", 8'h00, 4'b1000);
    // Shifts
    do_op(4'd7, 8'h81, 8'h01, 1'b0); expect_out("shl1", 8'h02, 4'b0010);
    do_op(4'd8, 8'h81, 8'h01, 1'b0); expect_out("shr1", 8'h40, 4'b0010);
    do_op(4'd7, 8'h81, 8'h00, 1'b0); expect_out("shl0", 8'h81, 4'b0100);
    do_op(4'd8, 8'h81, 8'h07, 1'b0); expect_out("shr7", 8'h01, 4'b0000);
    do_op(4'd12, 8'h55, 8'h33, 1'b0); expect_out("op12", 8'h00, 4'b1000);
    check("op12_acc", 16'(acc), 16'h01);

    // Multiplier: 0x12*0x10 = 0x120
    do_op(4'd9, 8'h12, 8'h10, 1'b0);
    check("mul_out_valid_clr", 16'(out_valid), 16'd0);
    for (int i = 0; i < W - 1; i++) begin
      check("mul_busy", 16'(busy), 16'd1);
      check("mul_in_ready", 16'(in_ready), 16'd0);
      tick();
    end
    check("mul_busy_last", 16'(busy), 16'd1);
    tick();
    check("mul_busy_done", 16'(busy), 16'd0);
    expect_out("mul_hi", 8'h20, 4'b0010);
    check("mul_acc", 16'(acc), 16'h20);
    do_op(4'd9, 8'h03, 8'h05, 1'b0);
    for (int i = 0; i < W; i++) tick();
    expect_out("mul_lo", 8'h0F, 4'b0000);

    // Backpressure: result held, second op stalled, then back-to-back transfer
    do_op(4'd0, 8'h01, 8'h01, 1'b0);
    out_ready = 1'b0;
    expect_out("bp_first", 8'h02, 4'b0000);
    op = 4'd0; a = 8'h03; b = 8'h04; use_acc = 1'b0; in_valid = 1'b1;
    #1;
    check("bp_in_ready_lo", 16'(in_ready), 16'd0);
    tick();
    expect_out("bp_hold", 8'h02, 4'b0000);
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_hi", 16'(in_ready), 16'd1);
    tick();
    in_valid = 1'b0;
    expect_out("bp_b2b", 8'h07, 4'b0000);
    tick();
    check("bp_drain", 16'(out_valid), 16'd0);

    // Accumulator operand and CMP
    do_op(4'd0, 8'h08, 8'h08, 1'b0); check("acc_seed", 16'(acc), 16'h10);
    do_op(4'd0, 8'hFF, 8'h05, 1'b1); expect_out("acc_add", 8'h15, 4'b0000);
    check("acc_add_acc", 16'(acc), 16'h15);
    do_op(4'd11, 8'hFF, 8'h10, 1'b1); expect_out("cmp", 8'h15, 4'b0000);
    check("cmp_acc", 16'(acc), 16'h15);

    // ena=0 freezes: out_ready ignored, nothing accepted
    ena = 1'b0; in_valid = 1'b1; op = 4'd6; b = 8'h77;
    #1;
    check("ena0_in_ready", 16'(in_ready), 16'd0);
    tick();
    in_valid = 1'b0;
    expect_out("ena0_hold", 8'h15, 4'b0000);
    ena = 1'b1;

    // Reset during a multiply
    do_op(4'd9, 8'h12, 8'h10, 1'b0);
    tick(); tick(); tick();
    check("abort_busy_pre", 16'(busy), 16'd1);
    rst = 1'b1;
    tick();
    check("abort_out_valid", 16'(out_valid), 16'd0);
    check("abort_acc", 16'(acc), 16'd0);
    check("abort_busy", 16'(busy), 16'd0);
    check("abort_result", 16'(result), 16'd0);
    check("abort_in_ready_rst", 16'(in_ready), 16'd0);
    rst = 1'b0;
    #1;
    check("abort_in_ready", 16'(in_ready), 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
